alu_nzcv_stage: RTL and testbench

Registered output stage directly downstream of the basic ALU. It captures the ALU result and carry-out together with the operands and control that produced them. It derives the NZCV condition flags and presents result plus flags to the consumer over a valid/ready handshake. It also holds the architectural flag register, which updates only for operations marked as flag-setting.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/nzcv_calc.sv | 37 +++
 rtl/alu_nzcv_stage.sv | 150 +++++++++++++++
 tb/tb_alu_nzcv_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU output stage: ALU opcode enum, NZCV bit positions
// and the packed NZCV flag struct.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Field order puts n at bit FLAG_N and v at bit FLAG_V.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/nzcv_calc.sv
// Combinational NZCV derivation from ALU operands, opcode, result and carry-out.
// C uses the ARM no-borrow convention for subtraction.
module nzcv_calc
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_ctrl_e    alu_ctrl_i,
    input  logic [N-1:0] result_i,
    input  logic         carry_i,
    output nzcv_t        nzcv_o
);

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        nzcv_o   = '0;
        nzcv_o.n = result_i[N-1];
        nzcv_o.z = (result_i == '0);
        case (alu_ctrl_i)
            ALU_ADD: begin
                nzcv_o.c = carry_i;
                nzcv_o.v = (a_i[N-1] == b_i[N-1]) && (result_i[N-1] != a_i[N-1]);
            end
            ALU_SUB: begin
                nzcv_o.c = carry_i;
                nzcv_o.v = (a_i[N-1] != b_i[N-1]) && (result_i[N-1] != a_i[N-1]);
            end
            default: begin
                nzcv_o.c = 1'b0;
                nzcv_o.v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_nzcv_stage.sv
// Registered ALU output stage: stores result plus NZCV per entry, valid/ready on
// both sides, architectural flag register. ALU_NZCV_STAGE_SKID_EN selects a
// 2-entry skid buffer with registered o_ready; otherwise a single entry.
module alu_nzcv_stage
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_alu_ctrl,
    input  logic [N-1:0] i_result,
    input  logic         i_carry_out,
    input  logic         i_set_flags,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_nzcv,
    output logic [3:0]   o_flags
);

    typedef struct packed {
        logic [N-1:0] result;
        nzcv_t        nzcv;
        logic         set_flags;
    } entry_t;

    entry_t     in_entry;
    nzcv_t      in_nzcv;
    entry_t     head_q, head_d;
    nzcv_t      flags_q, flags_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    nzcv_calc #(.N(N)) u_nzcv_calc (
        .a_i        (i_a),
        .b_i        (i_b),
        .alu_ctrl_i (alu_ctrl_e'(i_alu_ctrl)),
        .result_i   (i_result),
        .carry_i    (i_carry_out),
        .nzcv_o     (in_nzcv)
    );

    assign in_entry = '{result: i_result, nzcv: in_nzcv, set_flags: i_set_flags};
    assign push     = i_valid && o_ready;
    assign pop      = o_valid && i_ready;

    assign o_valid  = (count_q != 2'd0);
    assign o_result = head_q.result;
    assign o_nzcv   = head_q.nzcv;
    assign o_flags  = flags_q;

`ifdef ALU_NZCV_STAGE_SKID_EN
    entry_t skid_q, skid_d;
    logic   ready_q;

    // Head always holds the oldest entry; skid only fills while head is stalled.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    skid_d  = in_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            end
        endcase
    end

    assign o_ready = ready_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            skid_q  <= skid_d;
            ready_q <= (count_d != 2'd2);
        end
    end
`else
    logic live_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (push) begin
            head_d  = in_entry;
            count_d = 2'd1;
        end else if (pop) begin
            count_d = 2'd0;
        end
    end

    // live_q keeps o_ready low until the first edge after reset release.
    assign o_ready = live_q && (!o_valid || i_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        flags_d = flags_q;
        if (pop && head_q.set_flags) begin
            flags_d = head_q.nzcv;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state is updated with <= only, and every entry register is reset so
        // o_result/o_nzcv read zero after reset.
        if (!i_rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            flags_q <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_nzcv_stage.sv
// Self-checking bench for alu_nzcv_stage (N=64): flag vector table, full-rate
// streaming, backpressure with a scoreboard, and reset mid-stream.
module tb_alu_nzcv_stage;

    localparam int N = 64;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic [1:0]   i_alu_ctrl;
    logic [N-1:0] i_result;
    logic         i_carry_out;
    logic         i_set_flags;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_result;
    logic [3:0]   o_nzcv;
    logic [3:0]   o_flags;

    int checks = 0;
    int errors = 0;

    alu_nzcv_stage #(.N(N)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_alu_ctrl  (i_alu_ctrl),
        .i_result    (i_result),
        .i_carry_out (i_carry_out),
        .i_set_flags (i_set_flags),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_nzcv      (o_nzcv),
        .o_flags     (o_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]   ctrl;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         carry;
        logic         set;
        logic [3:0]   nzcv;
        logic [3:0]   flags;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ctrl, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] res,
                         input logic carry, input logic set);
        i_valid     = v;
        i_alu_ctrl  = ctrl;
        i_a         = a;
        i_b         = b;
        i_result    = res;
        i_carry_out = carry;
        i_set_flags = set;
    endtask

    initial begin
        logic [N-1:0] exp_q[$];
        logic [N-1:0] held_result;
        logic [3:0]   held_nzcv;
        logic         was_held;
        logic         push, pop, exp_ready;
        int           cnt, in_idx, retired;

        vecs[0] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1001, 4'b1001};
        vecs[1] = '{2'b10, 64'hF0, 64'h0F, 64'h0, 1'b0, 1'b0, 4'b0100, 4'b1001};
        vecs[2] = '{2'b01, 64'h5, 64'h5, 64'h0, 1'b1, 1'b1, 4'b0110, 4'b0110};
        vecs[3] = '{2'b01, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 4'b1000, 4'b1000};
        vecs[4] = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 4'b0111, 4'b0111};
        vecs[5] = '{2'b11, 64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 4'b1000, 4'b1000};
        vecs[6] = '{2'b01, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4'b0011, 4'b0011};
        vecs[7] = '{2'b00, 64'h1, 64'h2, 64'h3, 1'b0, 1'b0, 4'b0000, 4'b0011};

        // Reset state
        i_rst_n = 1'b0;
        i_ready = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        #1;
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_result", o_result, 64'd0);
        check("rst_nzcv", {60'd0, o_nzcv}, 64'd0);
        check("rst_flags", {60'd0, o_flags}, 64'd0);
        tick();
        tick();
        check("rst_ready_held_low", {63'd0, o_ready}, 64'd0);
        #2 i_rst_n = 1'b1;
        tick();
        check("ready_after_release", {63'd0, o_ready}, 64'd1);
        check("valid_after_release", {63'd0, o_valid}, 64'd0);

        // Flag vectors: accept with i_ready low, then retire on the next edge.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].carry, vecs[i].set);
            i_ready = 1'b0;
            tick();
            check($sformatf("vec%0d_valid", i), {63'd0, o_valid}, 64'd1);
            check($sformatf("vec%0d_result", i), o_result, vecs[i].res);
            check($sformatf("vec%0d_nzcv", i), {60'd0, o_nzcv}, {60'd0, vecs[i].nzcv});
            drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
            i_ready = 1'b1;
            tick();
            check($sformatf("vec%0d_flags", i), {60'd0, o_flags}, {60'd0, vecs[i].flags});
            check($sformatf("vec%0d_empty", i), {63'd0, o_valid}, 64'd0);
        end

        // Full rate: 8 back-to-back entries, one retire per cycle.
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'b10, 64'(k + 1), 64'(k + 1), 64'(k + 1), 1'b0, 1'b0);
            #1;
            check($sformatf("rate%0d_ready", k), {63'd0, o_ready}, 64'd1);
            tick();
            check($sformatf("rate%0d_valid", k), {63'd0, o_valid}, 64'd1);
            check($sformatf("rate%0d_result", k), o_result, 64'(k + 1));
        end
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        tick();
        check("rate_drained", {63'd0, o_valid}, 64'd0);

        // Backpressure: 4 entries, i_ready low on cycles 1..3.
        cnt = 0;
        in_idx = 0;
        retired = 0;
        was_held = 1'b0;
        held_result = '0;
        held_nzcv = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (was_held) begin
                check($sformatf("bp%0d_hold_result", cyc), o_result, held_result);
                check($sformatf("bp%0d_hold_nzcv", cyc), {60'd0, o_nzcv}, {60'd0, held_nzcv});
            end
            i_ready = !(cyc >= 1 && cyc <= 3);
            if (in_idx < 4) drive(1'b1, 2'b10, 64'h11 + 64'(in_idx), 64'h11 + 64'(in_idx), 64'h11 + 64'(in_idx), 1'b0, 1'b0);
            else            drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
            #1;
`ifdef ALU_NZCV_STAGE_SKID_EN
            exp_ready = (cnt != 2);
            if (cyc == 2) check("bp_ready_drop_after_2", {63'd0, o_ready}, 64'd0);
`else
            exp_ready = (cnt == 0) || i_ready;
`endif
            check($sformatf("bp%0d_ready", cyc), {63'd0, o_ready}, {63'd0, exp_ready});
            check($sformatf("bp%0d_valid", cyc), {63'd0, o_valid}, {63'd0, (cnt != 0)});
            push = i_valid && exp_ready;
            pop  = (cnt != 0) && i_ready;
            if (pop) begin
                check($sformatf("bp%0d_order", cyc), o_result, exp_q[0]);
                void'(exp_q.pop_front());
                retired++;
                cnt--;
            end
            if (push) begin
                exp_q.push_back(64'h11 + 64'(in_idx));
                in_idx++;
                cnt++;
            end
            was_held = o_valid && !i_ready;
            held_result = o_result;
            held_nzcv = o_nzcv;
            tick();
        end
        check("bp_retired", 64'(retired), 64'd4);
        check("bp_drained", {63'd0, o_valid}, 64'd0);
        check("flags_before_reset", {60'd0, o_flags}, 64'b0011);

        // Reset with entries held.
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'b01, 64'hA1 + 64'(k), 64'h0, 64'hA1 + 64'(k), 1'b1, 1'b1);
            tick();
        end
        check("mid_valid_before_reset", {63'd0, o_valid}, 64'd1);
        check("mid_result_before_reset", o_result, 64'hA1);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        check("mid_rst_flags", {60'd0, o_flags}, 64'd0);
        check("mid_rst_ready", {63'd0, o_ready}, 64'd0);
        check("mid_rst_result", o_result, 64'd0);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
        i_ready = 1'b1;
        tick();
        check("mid_rst_valid_after_edge", {63'd0, o_valid}, 64'd0);
        #2 i_rst_n = 1'b1;
        tick();
        check("mid_ready_after_release", {63'd0, o_ready}, 64'd1);
        check("mid_valid_after_release", {63'd0, o_valid}, 64'd0);
        check("mid_flags_after_release", {60'd0, o_flags}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
